// File: rtl/event_timestamper.sv
// -----------------------------------------------------------------------------
// event_timestamper
//
// Purpose
//   Turns a strobe back into a time: each rising edge on the asynchronous
//   event line is stamped with the free-running microsecond time base and
//   queued in a small show-ahead FIFO for the host register file.
//   The stamp is corrected for the fixed latency of the input synchroniser,
//   so it refers to the time the edge actually arrived.
//
// Ports
//   clk       in   1     system clock, everything on posedge
//   rst_n     in   1     asynchronous active-low reset
//   usec      in   TW    current time base, synchronous to clk
//   evt_in    in   1     asynchronous event line, rising edge = event
//   arm       in   1     capture enable, sampled at the write edge
//   clr       in   1     flush FIFO and clear ovf (wins over rd/write)
//   rd        in   1     pop the head entry
//   ts_out    out  TW    head entry, valid while ts_valid = 1
//   ts_valid  out  1     FIFO not empty
//   count     out  CW    entries held, 0..DEPTH
//   ovf       out  1     sticky: an event was dropped on a full FIFO
//   irq       out  1     count >= IRQ_LVL
//
// Handshake: the host may pulse rd whenever it likes. A pop happens only
// when rd is high at a posedge while ts_valid is high; the following entry
// (if any) is presented on ts_out from the next cycle on.
// -----------------------------------------------------------------------------
module event_timestamper #(
    parameter int unsigned TW       = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LAT_COMP = 2,
    parameter int unsigned IRQ_LVL  = 4,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] usec,
    input  logic          evt_in,
    input  logic          arm,
    input  logic          clr,
    input  logic          rd,
    output logic [TW-1:0] ts_out,
    output logic          ts_valid,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          irq
);

    localparam logic [TW-1:0] LAT_C   = TW'(LAT_COMP);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] IRQ_C   = CW'(IRQ_LVL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // ------------------------------------------------------------------
    // Input path: two flops of synchronisation plus one for edge detect.
    // ------------------------------------------------------------------
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= evt_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    logic evt_edge;
    assign evt_edge = s2_q & ~s3_q;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [TW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [TW-1:0] ts_out_q, ts_out_d;
    logic          valid_q,  valid_d;
    logic          ovf_q,    ovf_d;
    logic          irq_q,    irq_d;

    logic [TW-1:0] stamp;
    logic          full;
    logic          wr_req;
    logic          rd_ok;
    logic          store;
    logic          drop;

    // Two clocks elapse between the edge reaching the pins and the write,
    // so the stamp is pulled back by the path latency (wraps modulo 2^TW).
    assign stamp  = usec - LAT_C;
    assign full   = (count_q == DEPTH_C);
    assign wr_req = evt_edge & arm & ~clr;
    assign rd_ok  = rd & (count_q != '0) & ~clr;
    // On a full FIFO a simultaneous pop frees the slot being written.
    assign store  = wr_req & (~full | rd_ok);
    assign drop   = wr_req & full & ~rd_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ts_out_d = ts_out_q;
        ovf_d    = ovf_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end

            unique case ({store, rd_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            // Show-ahead head register. With two or more entries the
            // successor is already in memory; with exactly one entry the
            // only possible successor is the stamp arriving this cycle.
            if (rd_ok) begin
                if (count_q > CNT_ONE) begin
                    ts_out_d = mem_q[rd_ptr_q + PTR_ONE];
                end else if (store) begin
                    ts_out_d = stamp;
                end
            end else if (store && (count_q == '0)) begin
                ts_out_d = stamp;
            end
        end

        valid_d = (count_d != '0);
        irq_d   = (count_d >= IRQ_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ts_out_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ts_out_q <= ts_out_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    // Storage carries no reset; entries are only read once count says so.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= stamp;
        end
    end

    assign ts_out   = ts_out_q;
    assign ts_valid = valid_q;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign irq      = irq_q;

endmodule
